axi_trigger_s00_axi: RTL and testbench
======================================

Name: axi_trigger_s00_axi

Overview:
AXI4 full slave behind the AXITrigger block-design master port (S00_AXI).
Contains a word-addressed register/buffer memory that supports INCR bursts of up to 256 beats for both writes and reads.
Raises a one-cycle `trigger_o` pulse when a completed write burst sets bit 0 of the trigger word.
Directly consumes the traffic from the master VIP / PS master; `trigger_o` feeds the downstream trigger fabric.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported (fixed 4-byte beats, AxSIZE=2).
- C_S_AXI_ADDR_WIDTH, 6, byte address width; memory depth is 2^(C_S_AXI_ADDR_WIDTH-2) words (16 by default).
- TRIG_WORD, 0, word index whose bit 0 arms the trigger.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write burst start byte address
- S_AXI_AWLEN  in  8  write beats minus 1
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WLAST  in  1  last write beat
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read burst start byte address
- S_AXI_ARLEN  in  8  read beats minus 1
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response, always OKAY (2'b00)
- S_AXI_RLAST  out  1  last read beat
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- trigger_o  out  1  one-cycle trigger pulse

Behaviour:
- One clock; reset is asynchronous and active-low on S_AXI_ARESETN.
- Reset values:
  - All READY, VALID and RLAST outputs are 0; BRESP, RRESP and RDATA are 0; trigger_o is 0.
  - Memory is cleared to 0.
  - Both FSMs return to IDLE.
  - Reset mid-burst abandons the burst with no response.
- ID, LOCK, CACHE, PROT, QOS, REGION, USER and AxBURST/AxSIZE are not ports; the BD wrapper leaves them unconnected. Every burst is treated as INCR with 4-byte beats.
- Address arithmetic:
  - word index = addr[C_S_AXI_ADDR_WIDTH-1:2]; byte offset bits are ignored.
  - The index increments by 1 per beat and wraps modulo depth (15 -> 0 by default).
- Write FSM:
  - W_IDLE: AWREADY=1. On the AW handshake, latch the index and AWLEN, clear the beat count, go to W_DATA. AWREADY drops the cycle after the handshake.
  - W_DATA: WREADY=1. Each W handshake writes the strobed bytes (see Optional Feature), increments the index and increments the beat count.
    - On the WLAST beat, go to W_RESP.
    - Beats after count reaches AWLEN+1 are not written (WLAST still awaited).
    - BRESP=SLVERR (2'b10) if WLAST does not arrive exactly on beat AWLEN+1; otherwise OKAY.
  - W_RESP: BVALID=1 and held with BRESP stable until BREADY. Go to W_IDLE on the B handshake.
- Trigger:
  - A sticky flag records any beat of the current burst that writes TRIG_WORD with data bit 0 = 1 (strobe 0 active).
  - trigger_o=1 for exactly the one cycle after the B handshake if the flag is set; the flag then clears.
  - Bursts ending in SLVERR still trigger.
- Read FSM:
  - R_IDLE: ARREADY=1. On the AR handshake, latch the index and ARLEN, go to R_DATA.
  - R_DATA: RVALID=1 from the cycle after the AR handshake. RDATA = mem[index] sampled at the edge the beat is presented; it is held stable while RVALID && !RREADY.
    - RLAST=1 on beat ARLEN+1.
    - Each R handshake advances the index; the handshake on RLAST returns to R_IDLE.
- Concurrency: the read and write channels run independently. A read beat presented in the same cycle as a write to the same word returns the old value.
- Throughput: 1 beat per cycle with VALID/READY both held high; bubbles only at AW->W and AR->R entry.

Optional Feature:
- Macro: AXI_TRIGGER_WSTRB_EN.
- Defined: byte j of the word is written only when WSTRB[j]=1.
- Undefined: WSTRB is ignored and every accepted beat writes all 32 bits.
- The trigger rule is the same in both builds.

Test Plan:
- Write AWADDR=0, AWLEN=7, data 1..8 -> BRESP=0, trigger_o pulses once (word 0 = 1). Then read ARADDR=0, ARLEN=7 -> RDATA 1..8, RLAST on beat 8, RRESP=0.
- Wrap-around: write AWADDR=0x38, AWLEN=3, data A,B,C,D -> words 14,15,0,1 written. Read ARADDR=0 length 2 -> C,D.
- Backpressure:
  - Hold BREADY=0 for 5 cycles -> BVALID and BRESP stable, trigger_o only after the handshake.
  - Toggle RREADY every cycle -> RDATA stable while stalled, no beat skipped.
- Protocol error: AWLEN=3 with WLAST on beat 2 -> BRESP=2'b10, only 2 words written. Word 0 written with 0x2 -> no trigger.
- Reset: assert ARESETN low mid read burst (beat 3 of 8) -> RVALID=0 immediately, memory reads 0 after reset, next burst completes normally.
- With AXI_TRIGGER_WSTRB_EN: write 0xFFFFFFFF then 0x00000000 with WSTRB=4'b0101 -> read 0xFF00FF00. Without the macro -> read 0x00000000.

Source files
------------

// File: rtl/axi_trigger_s00_axi.sv
// rtl/axi_trigger_s00_axi.sv - AXI4 burst slave with word memory and write-triggered pulse
//
// Purpose : AXI4 full slave (INCR bursts up to 256 beats, 4-byte beats) in front of a
//           2^(C_S_AXI_ADDR_WIDTH-2)-word register/buffer memory. A completed write burst
//           that set bit 0 of word TRIG_WORD produces a one-cycle trigger_o pulse.
// Ports   : S_AXI_ACLK / S_AXI_ARESETN   clock, asynchronous active-low reset
//           S_AXI_AW*                    write address channel (AWADDR, AWLEN)
//           S_AXI_W*                     write data channel (WDATA, WSTRB, WLAST)
//           S_AXI_B*                     write response channel (BRESP)
//           S_AXI_AR*                    read address channel (ARADDR, ARLEN)
//           S_AXI_R*                     read data channel (RDATA, RRESP, RLAST)
//           trigger_o                    one-cycle pulse after the B handshake
// Macro   : AXI_TRIGGER_WSTRB_EN - when defined, WSTRB selects written bytes; otherwise
//           every accepted beat writes the whole word.

module axi_trigger_s00_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int TRIG_WORD          = 0
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            trigger_o
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
    localparam int IW    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IW;
    localparam logic [IW-1:0] TRIG_IDX = IW'(TRIG_WORD);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Write side state
    w_state_t      w_state_q, w_state_d;
    logic [IW-1:0] w_idx_q, w_idx_d;
    logic [7:0]    w_len_q, w_len_d;
    logic [8:0]    w_cnt_q, w_cnt_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          trig_flag_q, trig_flag_d;
    logic          trigger_q, trigger_d;
    logic          awready_q, awready_d;
    logic          wready_q, wready_d;
    logic          bvalid_q, bvalid_d;

    // Read side state
    r_state_t      r_state_q, r_state_d;
    logic [IW-1:0] r_idx_q, r_idx_d;
    logic [7:0]    r_len_q, r_len_d;
    logic [7:0]    r_cnt_q, r_cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic          rlast_q, rlast_d;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    logic          w_fire, r_fire, w_in_len, mem_we;
    logic [IW-1:0] r_idx_nxt;
    logic [DW-1:0] wr_word;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign w_fire    = wready_q && S_AXI_WVALID;
    assign r_fire    = rvalid_q && S_AXI_RREADY;
    // Beats past AWLEN+1 are acknowledged but must not touch memory.
    assign w_in_len  = (w_cnt_q <= {1'b0, w_len_q});
    assign r_idx_nxt = r_idx_q + 1'b1;

    // Word value produced by the current write beat.
    always_comb begin
        wr_word = mem_q[w_idx_q];
`ifdef AXI_TRIGGER_WSTRB_EN
        for (int j = 0; j < SW; j++) begin
            if (S_AXI_WSTRB[j]) begin
                wr_word[8*j +: 8] = S_AXI_WDATA[8*j +: 8];
            end
        end
`else
        wr_word = S_AXI_WDATA;
`endif
    end

`ifndef AXI_TRIGGER_WSTRB_EN
    // Only strobe bit 0 matters in this build (trigger qualification).
    logic unused_wstrb;
    assign unused_wstrb = ^S_AXI_WSTRB[SW-1:1];
`endif

    // Write FSM
    always_comb begin
        w_state_d   = w_state_q;
        w_idx_d     = w_idx_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        bresp_d     = bresp_q;
        trig_flag_d = trig_flag_q;
        trigger_d   = 1'b0;
        mem_we      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awready_q && S_AXI_AWVALID) begin
                    w_idx_d     = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    w_len_d     = S_AXI_AWLEN;
                    w_cnt_d     = '0;
                    trig_flag_d = 1'b0;
                    w_state_d   = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    if (w_in_len) begin
                        mem_we  = 1'b1;
                        // Caps at AWLEN+1, so a late WLAST still shows as a mismatch.
                        w_cnt_d = w_cnt_q + 9'd1;
                        if ((w_idx_q == TRIG_IDX) && S_AXI_WSTRB[0] && S_AXI_WDATA[0]) begin
                            trig_flag_d = 1'b1;
                        end
                    end
                    w_idx_d = w_idx_q + 1'b1;
                    if (S_AXI_WLAST) begin
                        bresp_d   = (w_cnt_q == {1'b0, w_len_q}) ? RESP_OKAY : RESP_SLVERR;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && S_AXI_BREADY) begin
                    trigger_d   = trig_flag_q;
                    trig_flag_d = 1'b0;
                    w_state_d   = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_comb begin
        mem_d = mem_q;
        if (mem_we) begin
            mem_d[w_idx_q] = wr_word;
        end
    end

    // Read FSM. RDATA is captured from mem_q at the presenting edge, so a
    // same-cycle write to that word is seen by the following beat, not this one.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: begin
                if (arready_q && S_AXI_ARVALID) begin
                    r_idx_d   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    r_len_d   = S_AXI_ARLEN;
                    r_cnt_d   = '0;
                    rdata_d   = mem_q[S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]];
                    rlast_d   = (S_AXI_ARLEN == 8'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_fire) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = r_idx_nxt;
                        r_cnt_d = r_cnt_q + 8'd1;
                        rdata_d = mem_q[r_idx_nxt];
                        rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q   <= W_IDLE;
            w_idx_q     <= '0;
            w_len_q     <= '0;
            w_cnt_q     <= '0;
            bresp_q     <= '0;
            trig_flag_q <= 1'b0;
            trigger_q   <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            r_state_q   <= R_IDLE;
            r_idx_q     <= '0;
            r_len_q     <= '0;
            r_cnt_q     <= '0;
            rdata_q     <= '0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            w_state_q   <= w_state_d;
            w_idx_q     <= w_idx_d;
            w_len_q     <= w_len_d;
            w_cnt_q     <= w_cnt_d;
            bresp_q     <= bresp_d;
            trig_flag_q <= trig_flag_d;
            trigger_q   <= trigger_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            r_state_q   <= r_state_d;
            r_idx_q     <= r_idx_d;
            r_len_q     <= r_len_d;
            r_cnt_q     <= r_cnt_d;
            rdata_q     <= rdata_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            mem_q       <= mem_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign trigger_o     = trigger_q;

endmodule

// File: tb/tb_axi_trigger_s00_axi.sv
// tb/tb_axi_trigger_s00_axi.sv - self-checking bench for axi_trigger_s00_axi

module tb_axi_trigger_s00_axi;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [5:0]  awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [5:0]  araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        trigger;

    always #5 clk = ~clk;

    axi_trigger_s00_axi dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (aresetn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWLEN   (awlen),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WLAST   (wlast),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .trigger_o     (trigger)
    );

    int errors = 0;
    int checks = 0;
    int trig_seen = 0;

    logic [31:0] model_mem [16];
    logic [31:0] wd [300];
    logic [3:0]  ws [300];
    logic [31:0] rd_buf [300];

    typedef struct {
        logic [5:0]  addr;
        logic [7:0]  len;
        int          nb;
        int          bdelay;
        logic [31:0] base;
        logic [1:0]  exp_resp;
        int          exp_trig;
    } wvec_t;

    wvec_t tbl [9];

    // Counts clock cycles with trigger high; a correct pulse adds exactly one.
    always @(negedge clk) if (trigger === 1'b1) trig_seen++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s: handshake not seen within bound", name);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
    endfunction

    // Reference: beat b lands in word (start+b) mod 16 while b <= len.
    function automatic void model_write(input logic [5:0] addr, input int len, input int nb,
                                        output logic [1:0] resp, output int trig);
        int idx;
        trig = 0;
        for (int b = 0; b < nb; b++) begin
            if (b <= len) begin
                idx = (int'(addr) / 4 + b) % 16;
`ifdef AXI_TRIGGER_WSTRB_EN
                for (int j = 0; j < 4; j++)
                    if (ws[b][j]) model_mem[idx][8*j +: 8] = wd[b][8*j +: 8];
`else
                model_mem[idx] = wd[b];
`endif
                if (idx == 0 && wd[b][0] && ws[b][0]) trig = 1;
            end
        end
        resp = (nb == len + 1) ? 2'b00 : 2'b10;
    endfunction

    task automatic axi_write(input logic [5:0] addr, input logic [7:0] len, input int nb,
                             input int bdelay, output logic [1:0] resp, output int trig);
        int guard;
        int t0;
        logic [1:0] r0;
        t0 = trig_seen;
        resp = 2'b11;
        awaddr = addr; awlen = len; awvalid = 1'b1;
        guard = 0;
        while (awready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) tmo("awready");
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == nb - 1); wvalid = 1'b1;
            guard = 0;
            while (wready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
            if (guard >= 50) tmo("wready");
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        guard = 0;
        while (bvalid !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) tmo("bvalid");
        r0 = bresp;
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            check("bvalid held", 32'(bvalid), 32'd1);
            check("bresp stable", 32'(bresp), 32'(r0));
            check("no trigger before B", 32'(trig_seen), 32'(t0));
        end
        bready = 1'b1;
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
        repeat (3) @(negedge clk);
        trig = trig_seen - t0;
    endtask

    // mode 0: RREADY high, 1: toggles every cycle, 2: random
    task automatic axi_read(input logic [5:0] addr, input logic [7:0] len, input int mode);
        int guard;
        int beat;
        int idx;
        logic stalled;
        logic [31:0] held;
        logic tog;
        araddr = addr; arlen = len; arvalid = 1'b1;
        guard = 0;
        while (arready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) tmo("arready");
        @(negedge clk);
        arvalid = 1'b0;
        beat = 0; guard = 0; stalled = 1'b0; tog = 1'b1;
        while (beat <= int'(len) && guard < 3000) begin
            case (mode)
                0: rready = 1'b1;
                1: begin rready = tog; tog = ~tog; end
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (rvalid === 1'b1) begin
                if (stalled) check("rdata held", rdata, held);
                if (rready) begin
                    idx = (int'(addr) / 4 + beat) % 16;
                    rd_buf[beat] = rdata;
                    check("rdata", rdata, model_mem[idx]);
                    check("rlast", 32'(rlast), 32'(beat == int'(len)));
                    check("rresp", 32'(rresp), 32'd0);
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = rdata;
                end
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) tmo("read beats");
        rready = 1'b0;
        check("rvalid after rlast", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] resp, eresp;
        int trig, etrig, n, guard, len, nb;
        logic [5:0] a;

        tbl[0] = '{6'h00, 8'd7,   8,   2, 32'h1,   2'b00, 1};
        tbl[1] = '{6'h38, 8'd3,   4,   0, 32'hA,   2'b00, 0};
        tbl[2] = '{6'h00, 8'd3,   2,   0, 32'h2,   2'b10, 0};
        tbl[3] = '{6'h3C, 8'd1,   2,   0, 32'h11,  2'b00, 0};
        tbl[4] = '{6'h04, 8'd0,   3,   1, 32'h20,  2'b10, 0};
        tbl[5] = '{6'h3C, 8'd2,   1,   0, 32'h31,  2'b10, 0};
        tbl[6] = '{6'h3C, 8'd3,   2,   5, 32'h40,  2'b10, 1};
        tbl[7] = '{6'h05, 8'd0,   1,   0, 32'h55,  2'b00, 0};
        tbl[8] = '{6'h00, 8'd255, 256, 0, 32'h100, 2'b00, 0};

        aresetn = 1'b0;
        awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("reset handshake outputs", 32'({awready, wready, bvalid, arready, rvalid, rlast, trigger}), 32'd0);
        check("reset resp", 32'({bresp, rresp}), 32'd0);
        check("reset rdata", rdata, 32'd0);
        aresetn = 1'b1;
        @(negedge clk);
        check("awready after reset", 32'(awready), 32'd1);
        check("arready after reset", 32'(arready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            for (int b = 0; b < tbl[i].nb; b++) begin
                wd[b] = tbl[i].base + 32'(b);
                ws[b] = 4'hF;
            end
            model_write(tbl[i].addr, int'(tbl[i].len), tbl[i].nb, eresp, etrig);
            axi_write(tbl[i].addr, tbl[i].len, tbl[i].nb, tbl[i].bdelay, resp, trig);
            check($sformatf("vec%0d bresp", i), 32'(resp), 32'(tbl[i].exp_resp));
            check($sformatf("vec%0d trigger pulses", i), 32'(trig), 32'(tbl[i].exp_trig));
            axi_read(6'h00, 8'd15, i % 3);
        end

        // Byte strobes
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        model_write(6'h08, 0, 1, eresp, etrig);
        axi_write(6'h08, 8'd0, 1, 0, resp, trig);
        wd[0] = 32'h0000_0000; ws[0] = 4'b0101;
        model_write(6'h08, 0, 1, eresp, etrig);
        axi_write(6'h08, 8'd0, 1, 0, resp, trig);
        axi_read(6'h08, 8'd0, 0);
`ifdef AXI_TRIGGER_WSTRB_EN
        check("strobe merge", rd_buf[0], 32'hFF00_FF00);
`else
        check("strobe ignored", rd_buf[0], 32'h0000_0000);
`endif

        // Reset in the middle of a read burst
        araddr = 6'h00; arlen = 8'd7; arvalid = 1'b1;
        guard = 0;
        while (arready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) tmo("arready pre-reset");
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0; guard = 0;
        while (n < 3 && guard < 50) begin
            if (rvalid === 1'b1) n++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) tmo("read beats pre-reset");
        check("rvalid beat 4 presented", 32'(rvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        check("rvalid drops in reset", 32'(rvalid), 32'd0);
        check("rdata cleared in reset", rdata, 32'd0);
        rready = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        model_clear();
        @(negedge clk);
        axi_read(6'h00, 8'd15, 0);

        // Randomized traffic against the reference model
        for (int it = 0; it < 25; it++) begin
            a = 6'($urandom_range(0, 63));
            len = $urandom_range(0, 20);
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 3) : len + 1;
            for (int b = 0; b < nb; b++) begin
                wd[b] = $urandom;
                ws[b] = 4'($urandom_range(0, 15));
            end
            model_write(a, len, nb, eresp, etrig);
            axi_write(a, 8'(len), nb, $urandom_range(0, 3), resp, trig);
            check("rand bresp", 32'(resp), 32'(eresp));
            check("rand trigger pulses", 32'(trig), 32'(etrig));
            axi_read(6'($urandom_range(0, 63)), 8'($urandom_range(0, 40)), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
